// File: rtl/bus_arbiter_pkg.sv
// Shared bus definitions for the system-bus arbiter and its round-robin picker.
// Covers active-low strobe levels, master indices and arbiter state encodings.
package bus_arbiter_pkg;

  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  localparam int NUM_MASTERS = 4;
  localparam int BUS_OWNER_W = 2;

  localparam logic [BUS_OWNER_W-1:0] BUS_OWNER_MASTER_0 = 2'd0;
  localparam logic [BUS_OWNER_W-1:0] BUS_OWNER_MASTER_1 = 2'd1;
  localparam logic [BUS_OWNER_W-1:0] BUS_OWNER_MASTER_2 = 2'd2;
  localparam logic [BUS_OWNER_W-1:0] BUS_OWNER_MASTER_3 = 2'd3;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_BUSY  = 2'd2
  } arb_state_e;

  // One-cold grant vector selecting a single master.
  function automatic logic [NUM_MASTERS-1:0] grant_vec(input logic [BUS_OWNER_W-1:0] idx);
    grant_vec = {NUM_MASTERS{DISABLE_}};
    grant_vec[idx] = ENABLE_;
  endfunction

endpackage

// File: rtl/bus_rr_pick.sv
// Combinational round-robin picker over four active-low requests.
// The search starts just after i_last and wraps, so i_last itself is considered last.
module bus_rr_pick
  import bus_arbiter_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] i_req_n,
  input  logic [BUS_OWNER_W-1:0] i_last,
  output logic [BUS_OWNER_W-1:0] o_winner,
  output logic                   o_valid
);

  // Walk from the farthest offset down to the nearest so the nearest requester wins.
  always_comb begin
    logic [BUS_OWNER_W-1:0] idx;
    o_winner = i_last;
    o_valid  = 1'b0;
    idx      = '0;
    for (int k = NUM_MASTERS; k >= 1; k--) begin
      idx = i_last + BUS_OWNER_W'(k);
      if (i_req_n[idx] == ENABLE_) begin
        o_winner = idx;
        o_valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin system-bus arbiter for four masters with active-low request/grant.
// Ownership moves only at transfer boundaries; optional preemption after MAX_XFER transfers.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int MAX_XFER = 0,
  parameter int OWNER_W  = BUS_OWNER_W
) (
  input  logic               clk,
  input  logic               reset_,
  input  logic               m0_req_,
  input  logic               m1_req_,
  input  logic               m2_req_,
  input  logic               m3_req_,
  input  logic               m_as_,
  input  logic               m_rdy_,
  output logic               m0_grnt_,
  output logic               m1_grnt_,
  output logic               m2_grnt_,
  output logic               m3_grnt_,
  output logic [OWNER_W-1:0] owner,
  output logic               busy
);

  localparam int CNT_W = (MAX_XFER < 1) ? 1 : $clog2(MAX_XFER + 1);

  arb_state_e                r_state;
  logic [NUM_MASTERS-1:0]    r_grnt;
  logic [BUS_OWNER_W-1:0]    r_owner;
  logic [BUS_OWNER_W-1:0]    r_lastOwner;
  logic [CNT_W-1:0]          r_cnt;

  arb_state_e                w_stateNext;
  logic [NUM_MASTERS-1:0]    w_grntNext;
  logic [BUS_OWNER_W-1:0]    w_ownerNext;
  logic [BUS_OWNER_W-1:0]    w_lastNext;
  logic [CNT_W-1:0]          w_cntNext;
  logic [CNT_W-1:0]          w_cntInc;
  logic [CNT_W-1:0]          w_cntEval;
  logic                      w_decide;

  logic [NUM_MASTERS-1:0]    w_reqN;
  logic [BUS_OWNER_W-1:0]    w_pickLast;
  logic [BUS_OWNER_W-1:0]    w_pickWinner;
  logic                      w_pickValid;
  logic                      w_ownerReq;
  logic                      w_othersPending;

  assign w_reqN = {m3_req_, m2_req_, m1_req_, m0_req_};

  // While granted, rotation starts after the current owner, which is then searched last.
  assign w_pickLast      = (r_state == ARB_IDLE) ? r_lastOwner : r_owner;
  assign w_ownerReq      = (w_reqN[r_owner] == ENABLE_);
  assign w_othersPending = w_pickValid && (w_pickWinner != r_owner);
  assign w_cntInc        = (int'(r_cnt) >= MAX_XFER) ? r_cnt : r_cnt + 1'b1;

  bus_rr_pick u_pick (
    .i_req_n  (w_reqN),
    .i_last   (w_pickLast),
    .o_winner (w_pickWinner),
    .o_valid  (w_pickValid)
  );

  always_comb begin
    w_stateNext = r_state;
    w_grntNext  = r_grnt;
    w_ownerNext = r_owner;
    w_lastNext  = r_lastOwner;
    w_cntNext   = r_cnt;
    w_cntEval   = r_cnt;
    w_decide    = 1'b0;

    case (r_state)
      ARB_IDLE: begin
        if (w_pickValid) begin
          w_stateNext = ARB_GRANT;
          w_grntNext  = grant_vec(w_pickWinner);
          w_ownerNext = w_pickWinner;
          w_cntNext   = '0;
        end
      end
      ARB_GRANT: begin
        if (m_as_ == ENABLE_) begin
          if (m_rdy_ == ENABLE_) begin
            w_cntNext = w_cntInc;
          end else begin
            w_stateNext = ARB_BUSY;
          end
        end else begin
          w_decide = 1'b1;
        end
      end
      ARB_BUSY: begin
        if (m_rdy_ == ENABLE_) begin
          w_stateNext = ARB_GRANT;
          w_cntNext   = w_cntInc;
          w_cntEval   = w_cntInc;
          w_decide    = 1'b1;
        end
      end
      default: begin
        w_stateNext = ARB_IDLE;
        w_grntNext  = {NUM_MASTERS{DISABLE_}};
      end
    endcase

    // Transfer boundary: the owner may hand over on release or after its quota.
    if (w_decide) begin
      if (!w_ownerReq) begin
        w_lastNext = r_owner;
        w_cntNext  = '0;
        if (w_pickValid) begin
          w_stateNext = ARB_GRANT;
          w_grntNext  = grant_vec(w_pickWinner);
          w_ownerNext = w_pickWinner;
        end else begin
          w_stateNext = ARB_IDLE;
          w_grntNext  = {NUM_MASTERS{DISABLE_}};
        end
      end else if ((MAX_XFER != 0) && (int'(w_cntEval) >= MAX_XFER) && w_othersPending) begin
        w_stateNext = ARB_GRANT;
        w_lastNext  = r_owner;
        w_cntNext   = '0;
        w_grntNext  = grant_vec(w_pickWinner);
        w_ownerNext = w_pickWinner;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state     <= ARB_IDLE;
      r_grnt      <= {NUM_MASTERS{DISABLE_}};
      r_owner     <= BUS_OWNER_MASTER_0;
      r_lastOwner <= BUS_OWNER_MASTER_3;
      r_cnt       <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_grnt      <= w_grntNext;
      r_owner     <= w_ownerNext;
      r_lastOwner <= w_lastNext;
      r_cnt       <= w_cntNext;
    end
  end

  assign m0_grnt_ = r_grnt[0];
  assign m1_grnt_ = r_grnt[1];
  assign m2_grnt_ = r_grnt[2];
  assign m3_grnt_ = r_grnt[3];
  assign owner    = OWNER_W'(r_owner);
  assign busy     = (r_state == ARB_BUSY);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: one instance with MAX_XFER=2 (dutA) and one
// with preemption disabled (dutB), both driven by the same master-side stimulus.
module tb_bus_arbiter;

  logic       clk    = 1'b0;
  logic       reset_ = 1'b0;
  logic [3:0] reqN   = 4'hF;
  logic       mAs_   = 1'b1;
  logic       mRdy_  = 1'b1;

  logic [3:0] grntA;
  logic [3:0] grntB;
  logic [1:0] ownerA;
  logic [1:0] ownerB;
  logic       busyA;
  logic       busyB;

  int assertCount = 0;
  int failCount   = 0;

  logic [1:0] rrOwners [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [3:0] rrGrants [5] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};

  always #5 clk = ~clk;

  bus_arbiter #(.MAX_XFER(2), .OWNER_W(2)) dutA (
    .clk(clk), .reset_(reset_),
    .m0_req_(reqN[0]), .m1_req_(reqN[1]), .m2_req_(reqN[2]), .m3_req_(reqN[3]),
    .m_as_(mAs_), .m_rdy_(mRdy_),
    .m0_grnt_(grntA[0]), .m1_grnt_(grntA[1]), .m2_grnt_(grntA[2]), .m3_grnt_(grntA[3]),
    .owner(ownerA), .busy(busyA)
  );

  bus_arbiter #(.MAX_XFER(0), .OWNER_W(2)) dutB (
    .clk(clk), .reset_(reset_),
    .m0_req_(reqN[0]), .m1_req_(reqN[1]), .m2_req_(reqN[2]), .m3_req_(reqN[3]),
    .m_as_(mAs_), .m_rdy_(mRdy_),
    .m0_grnt_(grntB[0]), .m1_grnt_(grntB[1]), .m2_grnt_(grntB[2]), .m3_grnt_(grntB[3]),
    .owner(ownerB), .busy(busyB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of master-side inputs, then sample just after the edge.
  task automatic applyStimulus(input logic [3:0] req, input logic as_, input logic rdy_);
    reqN  = req;
    mAs_  = as_;
    mRdy_ = rdy_;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reqN   = 4'hF;
    mAs_   = 1'b1;
    mRdy_  = 1'b1;
    reset_ = 1'b0;
    @(posedge clk);
    #1;
    reset_ = 1'b1;
  endtask

  initial begin
    // Reset state and idle behaviour
    @(posedge clk);
    #1;
    checkOutput("rst_grant", grntA, 4'hF);
    checkOutput("rst_owner", ownerA, 2'd0);
    checkOutput("rst_busy", busyA, 1'b0);
    reset_ = 1'b1;
    applyStimulus(4'hF, 1'b1, 1'b1);
    applyStimulus(4'hF, 1'b1, 1'b1);
    checkOutput("idle_grant", grntA, 4'hF);
    checkOutput("idle_owner", ownerA, 2'd0);

    // m0 and m2 request; m0 wins, then hands straight to m2
    doReset();
    applyStimulus(4'b1010, 1'b1, 1'b1);
    checkOutput("rel_m0_grant", grntA, 4'b1110);
    checkOutput("rel_m0_owner", ownerA, 2'd0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(4'b1010, 1'b1, 1'b1);
      checkOutput("rel_m0_hold", grntA, 4'b1110);
    end
    applyStimulus(4'b1011, 1'b1, 1'b1);
    checkOutput("rel_m2_grant", grntA, 4'b1011);
    checkOutput("rel_m2_owner", ownerA, 2'd2);
    applyStimulus(4'hF, 1'b1, 1'b1);
    checkOutput("rel_idle_grant", grntA, 4'hF);
    checkOutput("rel_park_owner", ownerA, 2'd2);

    // All request; dutA rotates every 2 transfers, dutB never preempts
    doReset();
    applyStimulus(4'h0, 1'b1, 1'b1);
    for (int k = 0; k < 5; k++) begin
      checkOutput("rr_owner", ownerA, rrOwners[k]);
      checkOutput("rr_grant", grntA, rrGrants[k]);
      applyStimulus(4'h0, 1'b0, 1'b0);
      checkOutput("rr_hold1", ownerA, rrOwners[k]);
      applyStimulus(4'h0, 1'b0, 1'b0);
      checkOutput("rr_hold2", grntA, rrGrants[k]);
      applyStimulus(4'h0, 1'b1, 1'b1);
    end
    checkOutput("rr_after_owner", ownerA, 2'd1);
    checkOutput("rr_nopreempt_owner", ownerB, 2'd0);

    // m1 locked in BUSY while it drops its request and m3 waits
    doReset();
    applyStimulus(4'b1101, 1'b1, 1'b1);
    checkOutput("lock_m1_grant", grntA, 4'b1101);
    applyStimulus(4'b0101, 1'b0, 1'b1);
    checkOutput("lock_busy", busyA, 1'b1);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'b0111, 1'b0, 1'b1);
      checkOutput("lock_busy_hold", busyA, 1'b1);
      checkOutput("lock_grant_hold", grntA, 4'b1101);
    end
    applyStimulus(4'b0111, 1'b0, 1'b0);
    checkOutput("lock_m3_grant", grntA, 4'b0111);
    checkOutput("lock_m3_owner", ownerA, 2'd3);
    checkOutput("lock_not_busy", busyA, 1'b0);

    // No preemption with MAX_XFER=0: m0 keeps grant across 10 transfers
    doReset();
    applyStimulus(4'b1100, 1'b1, 1'b1);
    checkOutput("nopre_m0_grant", grntB, 4'b1110);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(4'b1100, 1'b0, 1'b0);
      applyStimulus(4'b1100, 1'b1, 1'b1);
      checkOutput("nopre_m0_hold", grntB, 4'b1110);
    end
    applyStimulus(4'b1101, 1'b1, 1'b1);
    checkOutput("nopre_m1_grant", grntB, 4'b1101);
    checkOutput("nopre_m1_owner", ownerB, 2'd1);

    // Asynchronous reset in the middle of a BUSY transfer
    doReset();
    applyStimulus(4'b1011, 1'b1, 1'b1);
    checkOutput("arst_m2_grant", grntA, 4'b1011);
    applyStimulus(4'b1011, 1'b0, 1'b1);
    checkOutput("arst_busy", busyA, 1'b1);
    #3;
    reset_ = 1'b0;
    #1;
    checkOutput("arst_grantA", grntA, 4'hF);
    checkOutput("arst_grantB", grntB, 4'hF);
    checkOutput("arst_busy_clr", busyA, 1'b0);
    checkOutput("arst_owner", ownerA, 2'd0);
    #1;
    reset_ = 1'b1;
    applyStimulus(4'h0, 1'b1, 1'b1);
    checkOutput("arst_m0_first", ownerA, 2'd0);
    checkOutput("arst_m0_grant", grntA, 4'b1110);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
